// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
//   state_t : sequencer FSM states (IDLE, LOAD, EXEC, DONE)
//   OP_AND / OP_ADD : datapath select encodings carried on alu_sel
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic OP_AND = 1'b0;
  localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for one active-low
// pushbutton. All stages reset to 1 (released).
//   clk        : system clock
//   reset      : synchronous, active-high
//   not_button : raw active-low button, asynchronous to clk
//   press      : one-cycle pulse per press (synced 1 -> 0 transition)
module button_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic not_button,
  output logic press
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;
  logic settled;
  logic armed;

  // The stages reset to 1, so a button held through reset would look like a
  // fresh falling edge. Events are only armed once a genuine post-reset
  // sample has shown the button released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
      settled   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sync_1    <= not_button;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      settled   <= 1'b1;
      if (settled && sync_1) armed <= 1'b1;
    end
  end

  assign press = armed & sync_prev & ~sync_2;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the AND/ADD datapath from two active-low pushbuttons.
// LEFT requests AND, RIGHT requests ADD; requests are queued as pending bits
// and arbitrated round-robin against the last completed op.
//   clk, reset                : clock, synchronous active-high reset
//   not_LEFT/RIGHT_pushbutton : raw active-low buttons
//   A, B                      : operands from switches
//   alu_a, alu_b, alu_sel     : registered operands/select to datapath
//   alu_valid                 : high while the datapath is evaluated
//   alu_result                : datapath output
//   result, done              : captured result and its one-cycle strobe
//   busy, last_op, op_count   : status
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             not_LEFT_pushbutton,
  input  logic             not_RIGHT_pushbutton,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sel,
  output logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             last_op,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] exec_cnt;
  logic       pend_and;
  logic       pend_add;
  logic       ev_and;
  logic       ev_add;
  logic       grant_fire;
  logic       grant_op;

  button_sync_edge u_sync_left (
    .clk        (clk),
    .reset      (reset),
    .not_button (not_LEFT_pushbutton),
    .press      (ev_and)
  );

  button_sync_edge u_sync_right (
    .clk        (clk),
    .reset      (reset),
    .not_button (not_RIGHT_pushbutton),
    .press      (ev_add)
  );

  always_comb begin
    state_n    = state;
    grant_fire = 1'b0;
    // Both pending: alternate away from the last completed op.
    grant_op   = (pend_and && pend_add) ? ~last_op : pend_add;
    alu_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pend_and || pend_add) begin
          state_n    = S_LOAD;
          grant_fire = 1'b1;
        end
      end
      S_LOAD: state_n = S_EXEC;
      S_EXEC: begin
        alu_valid = 1'b1;
        if (exec_cnt == '0) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      exec_cnt <= '0;
      pend_and <= 1'b0;
      pend_add <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= 1'b0;
      result   <= '0;
      last_op  <= OP_ADD;
      op_count <= '0;
    end else begin
      state <= state_n;
      // A new press wins over a same-cycle grant of the same bit.
      pend_and <= ev_and | (pend_and & ~(grant_fire & (grant_op == OP_AND)));
      pend_add <= ev_add | (pend_add & ~(grant_fire & (grant_op == OP_ADD)));
      if (grant_fire) begin
        alu_a   <= A;
        alu_b   <= B;
        alu_sel <= grant_op;
      end
      if (state == S_LOAD) begin
        exec_cnt <= EXEC_LOAD;
      end else if (state == S_EXEC && exec_cnt != '0) begin
        exec_cnt <= exec_cnt - 4'd1;
      end
      if (state == S_EXEC && exec_cnt == '0) begin
        result   <= alu_result;
        op_count <= op_count + CNT_W'(1);
        last_op  <= alu_sel;
      end
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that sequences the 4-bit AND/ADD datapath from the two active-low pushbuttons.
- LEFT press requests AND; RIGHT press requests ADD. Buttons are synchronized, edge-detected and queued as pending requests. Simultaneous requests are arbitrated round-robin.
- For each granted request the block latches operands A/B, drives the datapath, captures its result and pulses done.
- Sits between the board switches/buttons and the combinational datapath; replaces direct button-to-select wiring.

Parameters:
- WIDTH, 4, operand/result width.
- EXEC_CYCLES, 1, cycles alu_valid is held before the result is sampled (range 1..15).
- CNT_W, 8, width of op_count.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- not_LEFT_pushbutton  in  1  active-low, asynchronous to clk; press requests AND.
- not_RIGHT_pushbutton  in  1  active-low, asynchronous to clk; press requests ADD.
- A  in  WIDTH  operand A from switches.
- B  in  WIDTH  operand B from switches.
- alu_a  out  WIDTH  registered operand A to datapath.
- alu_b  out  WIDTH  registered operand B to datapath.
- alu_sel  out  1  0=AND, 1=ADD.
- alu_valid  out  1  high while the datapath is being evaluated.
- alu_result  in  WIDTH  datapath output.
- result  out  WIDTH  captured result register.
- done  out  1  one-cycle pulse when result updates.
- busy  out  1  high whenever state is not IDLE.
- last_op  out  1  op of the most recently completed operation.
- op_count  out  CNT_W  completed-operation counter.

Behaviour:
- Reset values: all outputs 0 except last_op=1 (ADD). Pending bits cleared, state IDLE, both synchronizer stages set to 1.
- Synchronizer: 2 flops per button.
  - Press event = previous synced value 1 and current synced value 0 (falling edge).
  - Holding a button produces exactly one event.
  - A button held through reset produces no event until it is released and pressed again.
- Pending bits pend_and and pend_add:
  - A press event sets its bit.
  - A grant clears its bit.
  - If an event and a grant hit the same bit in the same cycle, set wins (the new request is kept).
  - A press while the bit is already set is absorbed; no double count.
- Arbitration, evaluated only in IDLE:
  - One bit set: grant it.
  - Both set: grant the op opposite to last_op. After reset this means AND first.
- FSM states: IDLE, LOAD, EXEC, DONE.
  - IDLE -> LOAD at the edge where any pending bit is set. At this edge: alu_a<=A, alu_b<=B, alu_sel<=grant; the granted pending bit clears.
  - LOAD -> EXEC after 1 cycle. alu_valid goes 1 and an internal counter loads EXEC_CYCLES-1.
  - EXEC: alu_valid=1. Counter decrements each cycle. When the counter reaches 0, the next edge captures result<=alu_result, op_count+=1 (wraps max->0), last_op<=alu_sel, and enters DONE.
  - DONE: done=1 and alu_valid=0 for one cycle, then -> IDLE.
- Latency: pending bit set at edge p gives done high in the cycle after edge p+2+EXEC_CYCLES. From the button falling edge, add 3 cycles (2 synchronizer stages + 1 edge-detect/pending register).
- A/B changes after LOAD are ignored until the next operation. alu_a/alu_b/alu_sel hold their values in IDLE.
- ADD result is truncated to WIDTH bits (carry discarded; 1100+1010 -> 0110).
- Back-to-back: a request pending at DONE is granted from IDLE on the next edge, so the minimum spacing between done pulses is EXEC_CYCLES+3 cycles.
- Reset mid-operation (any state): return to the reset values above the next edge. The in-flight op is lost; result and op_count are cleared.

Decomposition:
- Shared package alu_seq_pkg:
  - State encoding constants S_IDLE=2'd0, S_LOAD=2'd1, S_EXEC=2'd2, S_DONE=2'd3.
  - OP_AND=1'b0, OP_ADD=1'b1.
- One sub-module: button_sync_edge (2-flop synchronizer + falling-edge pulse, reset-to-1). Instantiated twice.
- The datapath itself is not instantiated inside this block. The bench connects a behavioural AND/ADD model to alu_*.

Test Plan:
1. Reset, A=1100, B=1010, press LEFT -> done once, alu_sel=0, result=1000, op_count=1, last_op=0, latency exactly 3+2+EXEC_CYCLES cycles from press.
2. A=1100, B=1010, press RIGHT -> result=0110 (carry dropped), last_op=1, op_count increments by 1.
3. Press both in the same cycle after reset, A=0001, B=0011 -> AND first (result=0001), then ADD (result=0100). Two done pulses spaced EXEC_CYCLES+3 apart; op_count=2.
4. Hold LEFT for 20 cycles -> exactly one operation. Change A to 1111 during EXEC -> result uses the operands latched at LOAD.
5. Press RIGHT, assert reset during EXEC -> next cycle: IDLE, result=0, op_count=0, busy=0, no done. Button still held -> no new op until released and re-pressed.
6. With CNT_W=8, run 256 ADD ops -> op_count wraps to 0. With EXEC_CYCLES=4, alu_valid is high for exactly 4 cycles per op.
